// File: rtl/display_ram_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_pkg                                                          |
// | Shared display-buffer widths, pointer type and pointer arithmetic.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package display_pkg;

    localparam int DISPLAY_DATA_BITS = 41;
    localparam int DISPLAY_ADDR_BITS = 4;

    // MSB is the wrap bit, so full and empty are distinguishable.
    typedef logic [DISPLAY_ADDR_BITS:0] display_ptr_t;

    function automatic display_ptr_t ptr_diff(input display_ptr_t a, input display_ptr_t b);
        return a - b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_ram_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_ram_reader_if                                                |
// | Pointer, RAM read port and output stream bundle of the read side.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface display_ram_reader_if
    import display_pkg::*;
#(
    parameter int DATA_BITS = DISPLAY_DATA_BITS,
    parameter int ADDR_BITS = DISPLAY_ADDR_BITS
) ();

    logic [ADDR_BITS:0]   wr_ptr;
    logic [ADDR_BITS:0]   rd_ptr;
    logic [ADDR_BITS-1:0] ram_rdaddress;
    logic                 ram_rden;
    logic [DATA_BITS-1:0] ram_q;
    logic [DATA_BITS-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 flush;
    logic [ADDR_BITS+1:0] rdusedw;
    logic                 overrun;

    modport slave (
        input  wr_ptr, ram_q, out_ready, flush,
        output rd_ptr, ram_rdaddress, ram_rden, out_data, out_valid, rdusedw, overrun
    );

    modport master (
        output wr_ptr, ram_q, out_ready, flush,
        input  rd_ptr, ram_rdaddress, ram_rden, out_data, out_valid, rdusedw, overrun
    );

endinterface
`default_nettype wire

// File: rtl/display_skid_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_skid_buf                                                     |
// | 2-entry register FIFO absorbing the RAM read latency.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module display_skid_buf
    import display_pkg::*;
#(
    parameter int DATA_BITS = DISPLAY_DATA_BITS
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic                 flush,
    input  wire logic                 push,
    input  wire logic [DATA_BITS-1:0] push_data,
    input  wire logic                 pop,
    output logic      [1:0]           occ,
    output logic      [DATA_BITS-1:0] head
);

    logic [1:0]           occ_q,  occ_d;
    logic [DATA_BITS-1:0] head_q, head_d;
    logic [DATA_BITS-1:0] tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            occ_d = 2'd0;
        end else begin
            case (occ_q)
                2'd0: if (push) begin
                    head_d = push_data;
                    occ_d  = 2'd1;
                end
                2'd1: if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d = push_data;
                    occ_d  = 2'd2;
                end else if (pop) begin
                    occ_d  = 2'd0;
                end
                2'd2: if (pop) begin
                    head_d = tail_q;
                    if (push) tail_d = push_data;
                    else      occ_d  = 2'd1;
                end
                default: occ_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ  = occ_q;
    assign head = head_q;

endmodule
`default_nettype wire

// File: rtl/display_ram_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | display_ram_reader                                                   |
// | Read-side controller of the display RAM: issue, skid, flush, overrun.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module display_ram_reader
    import display_pkg::*;
#(
    parameter int DATA_BITS = DISPLAY_DATA_BITS,
    parameter int ADDR_BITS = DISPLAY_ADDR_BITS
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    display_ram_reader_if.slave bus
);

    logic [ADDR_BITS:0]   rd_ptr_q, rd_ptr_d;
    logic                 inflight_q, inflight_d;
    logic                 overrun_q, overrun_d;
    logic [ADDR_BITS:0]   avail;
    logic [1:0]           occ;
    logic [1:0]           credit;
    logic [DATA_BITS-1:0] head;
    logic                 pop;
    logic                 issue;
    logic                 overrun_now;

    always_comb begin
        avail       = ptr_diff(bus.wr_ptr, rd_ptr_q);
        pop         = (occ != 2'd0) && bus.out_ready && !bus.flush;
        // Skid slots already claimed: words held plus the word returning from RAM.
        credit      = occ + {1'b0, inflight_q};
        issue       = !bus.flush && (avail != '0) &&
                      ((credit < 2'd2) || ((credit == 2'd2) && pop));
        overrun_now = avail[ADDR_BITS] && (avail[ADDR_BITS-1:0] != '0);
        rd_ptr_d    = bus.flush ? bus.wr_ptr : rd_ptr_q + {{ADDR_BITS{1'b0}}, issue};
        inflight_d  = issue;
        overrun_d   = !bus.flush && (overrun_q || overrun_now);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            overrun_q  <= overrun_d;
        end
    end

    display_skid_buf #(
        .DATA_BITS (DATA_BITS)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (bus.flush),
        .push      (inflight_q && !bus.flush),
        .push_data (bus.ram_q),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    assign bus.rd_ptr        = rd_ptr_q;
    assign bus.ram_rdaddress = rd_ptr_q[ADDR_BITS-1:0];
    assign bus.ram_rden      = issue;
    assign bus.out_data      = head;
    assign bus.out_valid     = (occ != 2'd0);
    assign bus.overrun       = overrun_q;
    assign bus.rdusedw       = {1'b0, avail}
                             + {{ADDR_BITS{1'b0}}, occ}
                             + {{(ADDR_BITS+1){1'b0}}, inflight_q};

endmodule
`default_nettype wire

// File: tb/tb_display_ram_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_display_ram_reader                                                |
// | Randomized bench with a word-queue reference model of the reader.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_display_ram_reader;
    import display_pkg::*;

    localparam int DW    = 41;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    display_ram_reader_if #(.DATA_BITS(DW), .ADDR_BITS(AW)) bus ();

    display_ram_reader #(.DATA_BITS(DW), .ADDR_BITS(AW)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] exp_q [$];
    int            wr_count = 0;
    int            pop_count = 0;
    bit            chk_en = 1'b0;
    bit            ovr_mode = 1'b0;
    int            rden_cnt = 0;
    int            cyc = 0;
    int            pops = 0;
    int            first_pop = 0;
    int            last_pop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Synchronous RAM with one cycle of read latency.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)          bus.ram_q <= '0;
        else if (bus.ram_rden) bus.ram_q <= mem[bus.ram_rdaddress];
    end

    // Reference: every written word leaves in write order; words not yet popped
    // equal writes minus pops; a flush discards everything outstanding.
    always @(negedge clk) begin
        cyc++;
        if (reset_n && chk_en) begin
            chk("rdaddr", {60'd0, bus.ram_rdaddress}, {60'd0, bus.rd_ptr[AW-1:0]});
            if (bus.ram_rden) rden_cnt++;
            if (!ovr_mode) begin
                chk("rdusedw", {58'd0, bus.rdusedw}, 64'(wr_count - pop_count));
                chk("overrun_idle", {63'd0, bus.overrun}, 64'd0);
                if (bus.out_valid && bus.out_ready && !bus.flush) begin
                    if (exp_q.size() == 0) chk("pop_empty", 64'd1, 64'd0);
                    else                   chk("out_data", {23'd0, bus.out_data}, {23'd0, exp_q.pop_front()});
                end
            end
            if (bus.out_valid && bus.out_ready && !bus.flush) begin
                pop_count++;
                pops++;
                if (pops == 1) first_pop = cyc;
                last_pop = cyc;
            end
            if (bus.flush) begin
                exp_q.delete();
                pop_count = wr_count;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction

    task automatic write_word(input logic [DW-1:0] d);
        mem[wr_count % DEPTH] = d;
        exp_q.push_back(d);
        wr_count++;
        bus.wr_ptr = wr_count[AW:0];
    endtask

    function automatic bit can_write();
        return (wr_count - pop_count) < DEPTH;
    endfunction

    task automatic drain(input string name);
        int b;
        b = 0;
        bus.out_ready = 1'b1;
        while (pop_count != wr_count && b < 100) begin
            tick();
            b++;
        end
        chk(name, 64'(pop_count == wr_count), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_rd_ptr"},  {59'd0, bus.rd_ptr}, 64'd0);
        chk({name, "_rden"},    {63'd0, bus.ram_rden}, 64'd0);
        chk({name, "_valid"},   {63'd0, bus.out_valid}, 64'd0);
        chk({name, "_data"},    {23'd0, bus.out_data}, 64'd0);
        chk({name, "_rdusedw"}, {58'd0, bus.rdusedw}, 64'd0);
        chk({name, "_overrun"}, {63'd0, bus.overrun}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int written;
        int budget;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bus.wr_ptr    = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        reset_n       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // First word latency: rden in cycle N, visible from cycle N+2.
        tick();
        write_word(41'h1_2345_6789);
        @(negedge clk);
        chk("lat_rden_N", {63'd0, bus.ram_rden}, 64'd1);
        chk("lat_valid_N", {63'd0, bus.out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_valid_N1", {63'd0, bus.out_valid}, 64'd0);
        @(negedge clk);
        chk("lat_valid_N2", {63'd0, bus.out_valid}, 64'd1);
        chk("lat_data_N2", {23'd0, bus.out_data}, 64'h1_2345_6789);
        tick();
        drain("lat_drain");

        // 40-word stream through the pointer wrap, no bubbles.
        pops = 0;
        written = 0;
        budget = 0;
        while (written < 40 && budget < 400) begin
            tick();
            budget++;
            if (can_write()) begin
                write_word(rnd_word());
                written++;
            end
        end
        drain("stream_drain");
        chk("stream_pops", 64'(pops), 64'd40);
        chk("stream_nogap", 64'(last_pop - first_pop), 64'd39);
        @(negedge clk);
        chk("stream_rdusedw", {58'd0, bus.rdusedw}, 64'd0);
        chk("stream_rd_ptr", {59'd0, bus.rd_ptr}, 64'(wr_count % 32));

        // Stall: only two reads may be issued while the consumer is blocked.
        tick();
        bus.out_ready = 1'b0;
        rden_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            write_word(rnd_word());
        end
        repeat (10) tick();
        chk("stall_reads", 64'(rden_cnt), 64'd2);
        @(negedge clk);
        chk("stall_rdusedw", {58'd0, bus.rdusedw}, 64'd8);
        chk("stall_valid", {63'd0, bus.out_valid}, 64'd1);
        tick();
        pops = 0;
        drain("stall_drain");
        chk("stall_pops", 64'(pops), 64'd8);
        chk("stall_nogap", 64'(last_pop - first_pop), 64'd7);

        // out_ready toggling every cycle over 16 words.
        pops = 0;
        written = 0;
        budget = 0;
        while ((written < 16 || pop_count != wr_count) && budget < 200) begin
            tick();
            budget++;
            bus.out_ready = ~bus.out_ready;
            if (written < 16 && can_write()) begin
                write_word(rnd_word());
                written++;
            end
        end
        chk("toggle_pops", 64'(pops), 64'd16);

        // Random writer and consumer traffic.
        for (int i = 0; i < 300; i++) begin
            tick();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (can_write() && $urandom_range(0, 1) == 1) write_word(rnd_word());
        end
        drain("random_drain");

        // Flush while a read is in flight.
        tick();
        bus.out_ready = 1'b0;
        rden_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            write_word(rnd_word());
        end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("flush_rd_ptr", {59'd0, bus.rd_ptr}, 64'(wr_count % 32));
        chk("flush_rdusedw", {58'd0, bus.rdusedw}, 64'd0);
        repeat (3) tick();
        chk("flush_reads", 64'(rden_cnt), 64'd2);
        @(negedge clk);
        chk("flush_no_push", {63'd0, bus.out_valid}, 64'd0);
        tick();
        write_word(rnd_word());
        drain("flush_after");

        // Overrun: avail 16 is legal, 17 sets the sticky flag, flush clears it.
        tick();
        bus.out_ready = 1'b0;
        ovr_mode = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            write_word(rnd_word());
        end
        repeat (3) tick();
        @(negedge clk);
        chk("ovr_full_flag", {63'd0, bus.overrun}, 64'd0);
        chk("ovr_full_rdusedw", {58'd0, bus.rdusedw}, 64'd18);
        tick();
        write_word(rnd_word());
        repeat (2) tick();
        @(negedge clk);
        chk("ovr_set", {63'd0, bus.overrun}, 64'd1);
        tick();
        bus.out_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        chk("ovr_sticky", {63'd0, bus.overrun}, 64'd1);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("ovr_flush_clr", {63'd0, bus.overrun}, 64'd0);
        chk("ovr_flush_rdusedw", {58'd0, bus.rdusedw}, 64'd0);
        tick();
        ovr_mode = 1'b0;

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 5; i++) begin
            tick();
            write_word(rnd_word());
        end
        @(negedge clk);
        #2;
        chk_en        = 1'b0;
        reset_n       = 1'b0;
        bus.wr_ptr    = '0;
        wr_count      = 0;
        pop_count     = 0;
        exp_q.delete();
        #1;
        check_reset_outputs("async_rst");
        tick();
        reset_n = 1'b1;
        chk_en  = 1'b1;
        pops = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            write_word(rnd_word());
        end
        drain("post_rst_drain");
        chk("post_rst_pops", 64'(pops), 64'd10);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
